// File: rtl/datapath_pool_router_pkg.sv
// Shared widths and unit state encoding for the datapath pool router.
package datapath_pool_router_pkg;

  localparam int unsigned INSTRUCTION_WIDTH = 32;
  localparam int unsigned RESULT_WIDTH      = 32;

  typedef enum logic [1:0] {
    UNIT_IDLE  = 2'd0,
    UNIT_ISSUE = 2'd1,
    UNIT_WAIT  = 2'd2
  } unit_state_e;

endpackage

// File: rtl/datapath_pool_router_if.sv
// Thread-side and datapath-bank-side bus of the pool router.
interface datapath_pool_router_if
  import datapath_pool_router_pkg::*;
#(
  parameter int unsigned PORTS    = 8,
  parameter int unsigned UNITS    = 2,
  parameter int unsigned INSTR_W  = INSTRUCTION_WIDTH,
  parameter int unsigned RESULT_W = RESULT_WIDTH
);

  logic [PORTS*INSTR_W-1:0]  instruction;
  logic [PORTS-1:0]          start;
  logic [PORTS*RESULT_W-1:0] result;
  logic [PORTS-1:0]          finished;
  logic [UNITS*INSTR_W-1:0]  instruction_dp;
  logic [UNITS-1:0]          start_dp;
  logic [UNITS*RESULT_W-1:0] result_dp;
  logic [UNITS-1:0]          finished_dp;

  // Environment view: drives thread requests and datapath responses
  modport master (
    output instruction, start, result_dp, finished_dp,
    input  result, finished, instruction_dp, start_dp
  );

  // Router view
  modport slave (
    input  instruction, start, result_dp, finished_dp,
    output result, finished, instruction_dp, start_dp
  );

endinterface

// File: rtl/datapath_pool_router_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, circular.
module datapath_pool_router_rr_arbiter #(
  parameter  int unsigned N     = 8,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic             grant_valid_c_o,
  output logic [PTR_W-1:0] grant_idx_c_o
);

  logic [PTR_W:0] idx_c;

  // Walk requesters from ptr_i with an explicit wrap, first hit wins
  always_comb begin
    grant_valid_c_o = 1'b0;
    grant_idx_c_o   = '0;
    idx_c           = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx_c = {1'b0, ptr_i} + (PTR_W+1)'(i);
      if (idx_c >= (PTR_W+1)'(N)) begin
        idx_c = idx_c - (PTR_W+1)'(N);
      end
      if (!grant_valid_c_o && req_i[idx_c[PTR_W-1:0]]) begin
        grant_valid_c_o = 1'b1;
        grant_idx_c_o   = idx_c[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/datapath_pool_router.sv
// Shares UNITS datapaths among PORTS threads: round-robin dispatch to the lowest
// idle unit, owner tagging, and result write-back to the owning port.
module datapath_pool_router
  import datapath_pool_router_pkg::*;
#(
  parameter int unsigned PORTS    = 8,
  parameter int unsigned UNITS    = 2,
  parameter int unsigned INSTR_W  = INSTRUCTION_WIDTH,
  parameter int unsigned RESULT_W = RESULT_WIDTH
) (
  input logic                   clock,
  input logic                   resetn,
  datapath_pool_router_if.slave bus
);

  localparam int unsigned PTR_W  = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int unsigned UNIT_W = (UNITS > 1) ? $clog2(UNITS) : 1;

  logic [INSTR_W-1:0]  instr_in     [PORTS];
  logic [RESULT_W-1:0] result_dp_in [UNITS];

  logic [PORTS-1:0]    pending_q, pending_d;
  logic [PORTS-1:0]    in_flight_q, in_flight_d;
  logic [PORTS-1:0]    finished_q, finished_d;
  logic [RESULT_W-1:0] result_q [PORTS];
  logic [RESULT_W-1:0] result_d [PORTS];
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    owner_q [UNITS];
  logic [PTR_W-1:0]    owner_d [UNITS];
  logic [INSTR_W-1:0]  instr_dp_q [UNITS];
  logic [INSTR_W-1:0]  instr_dp_d [UNITS];
  logic [UNITS-1:0]    start_dp_q, start_dp_d;

  logic [UNITS-1:0]    unit_idle_c;
  logic [UNITS-1:0]    unit_done_c;
  logic [UNITS-1:0]    dispatch_c;
  logic                grant_valid_c;
  logic [PTR_W-1:0]    grant_idx_c;
  logic                free_valid_c;
  logic [UNIT_W-1:0]   free_unit_c;

  // Flat bus slices to per-port / per-unit arrays
  for (genvar p = 0; p < PORTS; p++) begin : g_port
    assign instr_in[p]                               = bus.instruction[p*INSTR_W +: INSTR_W];
    assign bus.result[p*RESULT_W +: RESULT_W]        = result_q[p];
  end

  for (genvar u = 0; u < UNITS; u++) begin : g_unit_io
    assign result_dp_in[u]                           = bus.result_dp[u*RESULT_W +: RESULT_W];
    assign bus.instruction_dp[u*INSTR_W +: INSTR_W]  = instr_dp_q[u];
  end

  assign bus.finished = finished_q;
  assign bus.start_dp = start_dp_q;

  datapath_pool_router_rr_arbiter #(
    .N (PORTS)
  ) u_arb (
    .req_i           (pending_q & ~in_flight_q),
    .ptr_i           (rr_ptr_q),
    .grant_valid_c_o (grant_valid_c),
    .grant_idx_c_o   (grant_idx_c)
  );

  // Per-unit IDLE -> ISSUE -> WAIT sequencer
  for (genvar u = 0; u < UNITS; u++) begin : g_unit
    unit_state_e state_q, state_d;

    always_ff @(posedge clock) begin
      if (!resetn) begin
        state_q <= UNIT_IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        UNIT_IDLE:  if (dispatch_c[u]) state_d = UNIT_ISSUE;
        UNIT_ISSUE: state_d = UNIT_WAIT;
        UNIT_WAIT:  if (bus.finished_dp[u]) state_d = UNIT_IDLE;
        default:    state_d = UNIT_IDLE;
      endcase
    end

    assign unit_idle_c[u] = (state_q == UNIT_IDLE);
    assign unit_done_c[u] = (state_q == UNIT_WAIT) && bus.finished_dp[u];
  end

  // Request capture, write-back and dispatch; the three never touch the same port
  always_comb begin
    pending_d    = pending_q;
    in_flight_d  = in_flight_q;
    finished_d   = finished_q;
    result_d     = result_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    instr_dp_d   = instr_dp_q;
    start_dp_d   = '0;
    dispatch_c   = '0;
    free_valid_c = 1'b0;
    free_unit_c  = '0;

    for (int unsigned u = 0; u < UNITS; u++) begin
      if (!free_valid_c && unit_idle_c[u]) begin
        free_valid_c = 1'b1;
        free_unit_c  = UNIT_W'(u);
      end
    end

    for (int unsigned p = 0; p < PORTS; p++) begin
      if (bus.start[p] && finished_q[p]) begin
        pending_d[p]  = 1'b1;
        finished_d[p] = 1'b0;
      end
    end

    for (int unsigned u = 0; u < UNITS; u++) begin
      if (unit_done_c[u]) begin
        result_d[owner_q[u]]    = result_dp_in[u];
        finished_d[owner_q[u]]  = 1'b1;
        in_flight_d[owner_q[u]] = 1'b0;
      end
    end

    if (grant_valid_c && free_valid_c) begin
      dispatch_c[free_unit_c]  = 1'b1;
      start_dp_d[free_unit_c]  = 1'b1;
      instr_dp_d[free_unit_c]  = instr_in[grant_idx_c];
      owner_d[free_unit_c]     = grant_idx_c;
      in_flight_d[grant_idx_c] = 1'b1;
      pending_d[grant_idx_c]   = 1'b0;
      rr_ptr_d = (grant_idx_c == PTR_W'(PORTS - 1)) ? '0 : grant_idx_c + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pending_q   <= '0;
      in_flight_q <= '0;
      finished_q  <= '1;
      rr_ptr_q    <= '0;
      start_dp_q  <= '0;
      for (int unsigned p = 0; p < PORTS; p++) begin
        result_q[p] <= '0;
      end
      for (int unsigned u = 0; u < UNITS; u++) begin
        owner_q[u]    <= '0;
        instr_dp_q[u] <= '0;
      end
    end else begin
      pending_q   <= pending_d;
      in_flight_q <= in_flight_d;
      finished_q  <= finished_d;
      rr_ptr_q    <= rr_ptr_d;
      start_dp_q  <= start_dp_d;
      result_q    <= result_d;
      owner_q     <= owner_d;
      instr_dp_q  <= instr_dp_d;
    end
  end

endmodule

// File: tb/tb_datapath_pool_router.sv
// Bench for datapath_pool_router (4 ports, 2 units): directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a transaction-level model.
module tb_datapath_pool_router;
  import datapath_pool_router_pkg::*;

  localparam int NP = 4;
  localparam int NU = 2;
  localparam int IW = INSTRUCTION_WIDTH;
  localparam int RW = RESULT_WIDTH;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  datapath_pool_router_if #(.PORTS(NP), .UNITS(NU), .INSTR_W(IW), .RESULT_W(RW)) bus ();

  datapath_pool_router #(.PORTS(NP), .UNITS(NU), .INSTR_W(IW), .RESULT_W(RW)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Ports: idle/finished, waiting, or running on a unit. Units: free, issuing (start pulse), busy.
  bit          m_fin   [NP];
  bit          m_pend  [NP];
  bit          m_busy  [NP];
  logic [RW-1:0] m_res [NP];
  int          m_phase [NU];   // 0 free, 1 issuing, 2 busy awaiting completion
  int          m_owner [NU];
  logic [IW-1:0] m_idp [NU];
  int          m_rr;

  bit  elig   [NP];
  bit  fin_pre[NP];
  int  ph_pre [NU];
  int  win, unit_sel;

  always @(posedge clock) begin
    if (!resetn) begin
      for (int p = 0; p < NP; p++) begin
        m_fin[p] = 1'b1; m_pend[p] = 1'b0; m_busy[p] = 1'b0; m_res[p] = '0;
      end
      for (int u = 0; u < NU; u++) begin
        m_phase[u] = 0; m_owner[u] = 0; m_idp[u] = '0;
      end
      m_rr = 0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        elig[p]    = m_pend[p] && !m_busy[p];
        fin_pre[p] = m_fin[p];
      end
      for (int u = 0; u < NU; u++) ph_pre[u] = m_phase[u];
      win = -1;
      for (int k = 0; k < NP; k++)
        if (win < 0 && elig[(m_rr + k) % NP]) win = (m_rr + k) % NP;
      unit_sel = -1;
      for (int u = 0; u < NU; u++)
        if (unit_sel < 0 && ph_pre[u] == 0) unit_sel = u;
      for (int u = 0; u < NU; u++) begin
        if (ph_pre[u] == 1) m_phase[u] = 2;
        else if (ph_pre[u] == 2 && bus.finished_dp[u]) begin
          m_res[m_owner[u]]  = bus.result_dp[u*RW +: RW];
          m_fin[m_owner[u]]  = 1'b1;
          m_busy[m_owner[u]] = 1'b0;
          m_phase[u]         = 0;
        end
      end
      for (int p = 0; p < NP; p++)
        if (bus.start[p] && fin_pre[p]) begin
          m_pend[p] = 1'b1;
          m_fin[p]  = 1'b0;
        end
      if (win >= 0 && unit_sel >= 0) begin
        m_idp[unit_sel]   = bus.instruction[win*IW +: IW];
        m_owner[unit_sel] = win;
        m_busy[win]       = 1'b1;
        m_pend[win]       = 1'b0;
        m_phase[unit_sel] = 1;
        m_rr              = (win + 1) % NP;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [NP-1:0]    e_fin;
  logic [NP*RW-1:0] e_res;
  logic [NU-1:0]    e_sdp;
  logic [NU*IW-1:0] e_idp;

  always @(negedge clock) begin
    if (check_en) begin
      for (int p = 0; p < NP; p++) begin
        e_fin[p] = m_fin[p];
        e_res[p*RW +: RW] = m_res[p];
      end
      for (int u = 0; u < NU; u++) begin
        e_sdp[u] = (m_phase[u] == 1);
        e_idp[u*IW +: IW] = m_idp[u];
      end
      chk("model finished", bus.finished, e_fin);
      chk("model result", bus.result, e_res);
      chk("model start_dp", bus.start_dp, e_sdp);
      chk("model instruction_dp", bus.instruction_dp, e_idp);
    end
  end

  // ---------------- stimulus ----------------
  task automatic quiet();
    bus.start       = '0;
    bus.finished_dp = '0;
  endtask

  task automatic do_reset(input int n);
    quiet();
    resetn = 1'b0;
    repeat (n) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  int grants[$];
  int exp_g[4] = '{3, 0, 3, 0};
  int g;

  initial begin
    bus.instruction = '0;
    bus.result_dp   = '0;
    quiet();
    @(posedge clock);
    #1 check_en = 1'b1;

    // Reset values hold for three cycles
    repeat (3) begin
      @(negedge clock);
      chk("reset finished", bus.finished, 4'b1111);
      chk("reset result", bus.result, '0);
      chk("reset start_dp", bus.start_dp, 2'b00);
    end
    resetn = 1'b1;

    // Single request on port 2
    bus.instruction[2*IW +: IW] = 32'hA5;
    bus.start = 4'b0100;
    cyc(1); bus.start = '0;
    chk("single finished cleared", bus.finished, 4'b1011);
    chk("single no early start_dp", bus.start_dp, 2'b00);
    cyc(1);
    chk("single start_dp", bus.start_dp, 2'b01);
    chk("single instruction_dp0", bus.instruction_dp[IW-1:0], 32'hA5);
    cyc(2);
    bus.finished_dp = 2'b01; bus.result_dp[RW-1:0] = 32'h77;
    cyc(1); bus.finished_dp = '0;
    chk("single result2", bus.result[2*RW +: RW], 32'h77);
    chk("single finished back", bus.finished, 4'b1111);
    chk("model pin result2", m_res[2], 32'h77);

    // All four request, units stall
    do_reset(2);
    for (int p = 0; p < NP; p++) bus.instruction[p*IW +: IW] = 32'h100 + p;
    bus.start = 4'b1111;
    cyc(1); bus.start = '0;
    chk("all finished cleared", bus.finished, 4'b0000);
    cyc(1);
    chk("all grant0 start_dp", bus.start_dp, 2'b01);
    chk("all grant0 instr", bus.instruction_dp[IW-1:0], 32'h100);
    cyc(1);
    chk("all grant1 start_dp", bus.start_dp, 2'b10);
    chk("all grant1 instr", bus.instruction_dp[IW +: IW], 32'h101);
    cyc(1);
    chk("all full no dispatch", bus.start_dp, 2'b00);
    bus.start = 4'b0001;   // busy port: must be ignored
    cyc(1); bus.start = '0;
    chk("busy start ignored", bus.start_dp, 2'b00);
    chk("busy finished unchanged", bus.finished, 4'b0000);
    bus.finished_dp = 2'b10; bus.result_dp[RW +: RW] = 32'hB1;
    cyc(1); bus.finished_dp = '0;
    chk("unit1 wb finished", bus.finished, 4'b0010);
    chk("unit1 wb result1", bus.result[RW +: RW], 32'hB1);
    cyc(1);
    chk("port2 to unit1 start_dp", bus.start_dp, 2'b10);
    chk("port2 to unit1 instr", bus.instruction_dp[IW +: IW], 32'h102);
    bus.finished_dp = 2'b01; bus.result_dp[RW-1:0] = 32'hB0;
    cyc(1); bus.finished_dp = '0;
    chk("unit0 wb finished", bus.finished, 4'b0011);
    chk("unit0 wb result0", bus.result[RW-1:0], 32'hB0);
    cyc(1);
    chk("port3 to unit0 start_dp", bus.start_dp, 2'b01);
    chk("port3 to unit0 instr", bus.instruction_dp[IW-1:0], 32'h103);

    // Fairness: port1 parks unit0, ports 0 and 3 share unit1
    do_reset(1);
    bus.instruction[0*IW +: IW] = 32'h300;
    bus.instruction[1*IW +: IW] = 32'h301;
    bus.instruction[3*IW +: IW] = 32'h303;
    bus.start = 4'b0010;
    cyc(1); bus.start = '0;
    cyc(1);
    bus.start = 4'b1001; bus.finished_dp = 2'b10; bus.result_dp[RW +: RW] = 32'h44;
    grants.delete();
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      @(negedge clock);
      if (bus.start_dp[1]) begin
        g = int'(bus.instruction_dp[IW +: IW]) - 'h300;
        grants.push_back(g);
      end
    end
    quiet();
    chk("fair grant count", 128'(grants.size()), 128'(4));
    for (int i = 0; i < grants.size() && i < 4; i++)
      chk("fair grant order", 128'(grants[i]), 128'(exp_g[i]));

    // Simultaneous completions, owners 1 and 3
    do_reset(1);
    bus.instruction[1*IW +: IW] = 32'h201;
    bus.instruction[3*IW +: IW] = 32'h203;
    bus.start = 4'b1010;
    cyc(1); bus.start = '0;
    cyc(1);
    chk("dual grant port1 unit0", bus.instruction_dp[IW-1:0], 32'h201);
    cyc(1);
    chk("dual grant port3 unit1", bus.instruction_dp[IW +: IW], 32'h203);
    cyc(1);
    bus.finished_dp = 2'b11; bus.result_dp = {32'h33, 32'h11};
    cyc(1); bus.finished_dp = '0;
    chk("dual finished", bus.finished, 4'b1111);
    chk("dual result1", bus.result[RW +: RW], 32'h11);
    chk("dual result3", bus.result[3*RW +: RW], 32'h33);

    // Reset while both units wait; late completions must be dropped
    do_reset(1);
    bus.start = 4'b1010;
    cyc(1); bus.start = '0;
    cyc(3);
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
    bus.finished_dp = 2'b11; bus.result_dp = {32'hEE, 32'hDD};
    repeat (2) begin
      cyc(1); bus.finished_dp = '0;
      chk("rst mid finished", bus.finished, 4'b1111);
      chk("rst mid result", bus.result, '0);
      chk("rst mid start_dp", bus.start_dp, 2'b00);
      chk("rst mid instruction_dp", bus.instruction_dp, '0);
    end

    // Randomized traffic against the model
    do_reset(1);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      resetn = ($urandom_range(0, 499) != 0);
      for (int p = 0; p < NP; p++) begin
        if (bus.finished[p]) bus.instruction[p*IW +: IW] = $urandom;
        bus.start[p] = ($urandom_range(0, 2) == 0);
      end
      for (int u = 0; u < NU; u++) begin
        bus.finished_dp[u] = ($urandom_range(0, 3) == 0);
        bus.result_dp[u*RW +: RW] = $urandom;
      end
    end
    quiet();
    resetn = 1'b1;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
